// File: rtl/fifo_stream_dwc.sv
// Serialises wide FIFO words into RATIO narrow valid/ready beats, back-to-back while the FIFO has data.
// Optional last_o output is enabled by defining FIFO_STREAM_DWC_LAST_EN.
module fifo_stream_dwc #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_pop_o,
  output logic [OUT_WIDTH-1:0]  data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o
`ifdef FIFO_STREAM_DWC_LAST_EN
  ,
  output logic                  last_o
`endif
);

  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_shifted;
  logic [CNT_W-1:0]      cnt;
  logic                  accept, word_done;

  assign accept    = (state == SEND) && ready_i;
  assign word_done = accept && (cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: defaults first in every combinational process, so no path leaves an output unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty_i) state_next = SEND;
      SEND:    if (word_done && fifo_empty_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pop is gated by reset so an asserted reset never consumes a FIFO word.
  always_comb begin
    fifo_pop_o = 1'b0;
    if (rst_n_i) begin
      case (state)
        IDLE:    fifo_pop_o = !fifo_empty_i;
        SEND:    fifo_pop_o = word_done && !fifo_empty_i;
        default: fifo_pop_o = 1'b0;
      endcase
    end
  end

  // The output chunk always sits at the same end of shreg; shifting moves the next chunk into it.
  generate
    if (RATIO > 1) begin : g_shift
      if (MSB_FIRST != 0) begin : g_msb
        assign shreg_shifted = {shreg[DATA_WIDTH-OUT_WIDTH-1:0], {OUT_WIDTH{1'b0}}};
        assign data_o        = shreg[DATA_WIDTH-1 -: OUT_WIDTH];
      end else begin : g_lsb
        assign shreg_shifted = {{OUT_WIDTH{1'b0}}, shreg[DATA_WIDTH-1:OUT_WIDTH]};
        assign data_o        = shreg[OUT_WIDTH-1:0];
      end
    end else begin : g_single
      assign shreg_shifted = shreg;
      assign data_o        = shreg;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (fifo_pop_o) begin
      shreg <= fifo_data_i;
      cnt   <= '0;
    end else if (accept && (cnt != CNT_LAST)) begin
      shreg <= shreg_shifted;
      cnt   <= cnt + 1'b1;
    end
  end

  assign valid_o = (state == SEND);
  assign busy_o  = (state == SEND);

`ifdef FIFO_STREAM_DWC_LAST_EN
  logic last_q;

  // Tracks cnt == CNT_LAST one cycle ahead so last_o comes straight from a flop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)       last_q <= 1'b0;
    else if (fifo_pop_o) last_q <= (RATIO == 1);
    else if (word_done)  last_q <= 1'b0;
    else if (accept)     last_q <= ((cnt + 1'b1) == CNT_LAST);
  end

  assign last_o = last_q;
`endif

endmodule

// File: tb/tb_fifo_stream_dwc.sv
// Checks fifo_stream_dwc (LSB-first and MSB-first instances) against a beat-queue reference model.
// Directed test-plan scenarios followed by randomized FIFO fill and backpressure.
module tb_fifo_stream_dwc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        ready;
  logic        pop, pop_m;
  logic [7:0]  data, data_m;
  logic        valid, valid_m, busy, busy_m;
`ifdef FIFO_STREAM_DWC_LAST_EN
  logic        last, last_m;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] fifo_q[$];
  logic [7:0]  exp_q[$], exp_m[$];
  logic [7:0]  log_q[$], log_m[$];

  always #5 clk = ~clk;

  fifo_stream_dwc #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty),
    .fifo_pop_o(pop), .data_o(data), .valid_o(valid), .ready_i(ready), .busy_o(busy)
`ifdef FIFO_STREAM_DWC_LAST_EN
    , .last_o(last)
`endif
  );

  fifo_stream_dwc #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk_i(clk), .rst_n_i(rst_n), .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty),
    .fifo_pop_o(pop_m), .data_o(data_m), .valid_o(valid_m), .ready_i(ready), .busy_o(busy_m)
`ifdef FIFO_STREAM_DWC_LAST_EN
    , .last_o(last_m)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, compare against the model, then advance the model at posedge.
  task automatic step(input bit rdy);
    logic        exp_valid, exp_pop;
    logic [31:0] w;
    @(negedge clk);
    ready      = rdy;
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? $urandom : fifo_q[0];
    #1;
    exp_valid = rst_n && (exp_q.size() > 0);
    exp_pop   = rst_n && !fifo_empty && (exp_q.size() == 0 || (exp_q.size() == 1 && rdy));
    check("pop",     pop,     exp_pop);
    check("pop_m",   pop_m,   exp_pop);
    check("valid",   valid,   exp_valid);
    check("valid_m", valid_m, exp_valid);
    check("busy",    busy,    exp_valid);
    check("busy_m",  busy_m,  exp_valid);
    if (exp_valid) begin
      check("data",   data,   exp_q[0]);
      check("data_m", data_m, exp_m[0]);
    end
`ifdef FIFO_STREAM_DWC_LAST_EN
    check("last",   last,   exp_valid && exp_q.size() == 1);
    check("last_m", last_m, exp_valid && exp_q.size() == 1);
`endif
    @(posedge clk);
    if (rst_n) begin
      if (exp_valid && rdy) begin
        log_q.push_back(data);
        log_m.push_back(data_m);
        void'(exp_q.pop_front());
        void'(exp_m.pop_front());
      end
      if (exp_pop) begin
        w = fifo_q.pop_front();
        for (int i = 0; i < 4; i++) begin
          exp_q.push_back(8'((w >> (8 * i)) & 32'hff));
          exp_m.push_back(8'((w >> (8 * (3 - i))) & 32'hff));
        end
      end
    end
  endtask

  task automatic check_log(input string tag, input logic [31:0] w, input bit msb);
    logic [7:0] want;
    check({tag, "_cnt"}, msb ? log_m.size() : log_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      want = msb ? 8'((w >> (8 * (3 - i))) & 32'hff) : 8'((w >> (8 * i)) & 32'hff);
      if (msb && i < log_m.size())  check({tag, "_beat"}, log_m[i], want);
      if (!msb && i < log_q.size()) check({tag, "_beat"}, log_q[i], want);
    end
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b1; fifo_empty = 1'b1; fifo_data = '0;

    // Reset with a non-empty FIFO: nothing popped, outputs at reset values.
    fifo_q.push_back(32'hA1B2C3D4);
    step(1); step(1);
    check("rst_data",   data,   8'h00);
    check("rst_data_m", data_m, 8'h00);
    #2 rst_n = 1'b1;

    // Single word, LSB first and MSB first.
    log_q.delete(); log_m.delete();
    repeat (6) step(1);
    check_log("single", 32'hA1B2C3D4, 1'b0);
    check_log("msb",    32'hA1B2C3D4, 1'b1);

    // Back-to-back words, no bubble between them.
    log_q.delete(); log_m.delete();
    fifo_q.push_back(32'h03020100);
    fifo_q.push_back(32'h07060504);
    repeat (10) step(1);
    check("b2b_cnt", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) check("b2b_beat", log_q[i], i);

    // Backpressure for 3 cycles while 0xC3 is presented.
    log_q.delete(); log_m.delete();
    fifo_q.push_back(32'hA1B2C3D4);
    step(1); step(1);
    repeat (3) begin
      step(0);
      check("bp_data", data, 8'hC3);
    end
    repeat (4) step(1);
    check_log("bp", 32'hA1B2C3D4, 1'b0);

    // Reset after two accepted beats; remaining chunks discarded.
    log_q.delete(); log_m.delete();
    fifo_q.push_back(32'hA1B2C3D4);
    step(1); step(1); step(1);
    fifo_q.push_back(32'h44332211);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valid", valid, 1'b0);
    check("midrst_data",  data,  8'h00);
    check("midrst_log",   log_q.size(), 2);
    exp_q.delete(); exp_m.delete();
    step(1); step(1);
    #2 rst_n = 1'b1;
    log_q.delete(); log_m.delete();
    repeat (6) step(1);
    check_log("post_rst", 32'h44332211, 1'b0);

    // Randomized fill and backpressure.
    for (int c = 0; c < 400; c++) begin
      if (fifo_q.size() < 4 && $urandom_range(2, 0) == 0) fifo_q.push_back($urandom);
      step($urandom_range(3, 0) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
